// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Memory-stage load/store unit. Takes the M-stage control and data
//   registered at the EX->MEM boundary, runs one req/ack bus transaction
//   per aligned access, and returns sign/zero-extended load data toward
//   MEM/WB. Misaligned accesses are dropped with a one-cycle flag, and a
//   bus that never acks is abandoned after TIMEOUT_CYCLES busy cycles.
//
// Ports
//   CLK, RST_N            clock (rising edge), async active-low reset
//   MemReadM, MemWriteM   load / store in M stage (write wins if both set)
//   Funct3M               000 B, 001 H, 010 W, 100 BU, 101 HU (011/11x = W)
//   AluResultM            byte address
//   WriteDataM            store data
//   ReadDataM             extended load data, valid in DONE
//   StallM                hold F/D/E/M stages
//   MisalignM             pulse: misaligned access dropped
//   BusErrM               pulse in DONE after a timeout abort
//   BusReq/BusWe/BusAddr/BusWdata/BusBe   bus request, held until BusAck
//   BusRdata, BusAck      bus response
//   DbgState              current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: BusReq rises on entry to BUSY and stays high, with BusWe,
// BusAddr, BusBe and BusWdata stable, until the cycle in which BusAck is
// sampled high at a rising edge; BusRdata is sampled in that same cycle.
// BusAck seen outside BUSY is ignored.
//
// Only WIDTH = 32 is supported; TIMEOUT_CYCLES must fit in 16 bits.

module mem_stage_lsu #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [2:0]       Funct3M,
  input  logic [WIDTH-1:0] AluResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] ReadDataM,
  output logic             StallM,
  output logic             MisalignM,
  output logic             BusErrM,
  output logic             BusReq,
  output logic             BusWe,
  output logic [WIDTH-1:0] BusAddr,
  output logic [WIDTH-1:0] BusWdata,
  output logic [3:0]       BusBe,
  input  logic [WIDTH-1:0] BusRdata,
  input  logic             BusAck,
  output logic [1:0]       DbgState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [29:0]      word_q, word_d;
  logic [1:0]       off_q, off_d;
  logic [3:0]       be_q, be_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]       f3_q, f3_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             access, aligned, size_h, size_w, timed_out;
  logic [3:0]       be_new;
  logic [WIDTH-1:0] wdata_new, rd_shift, ld_ext;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  // Request decode in IDLE
  always_comb begin
    access  = MemReadM | MemWriteM;
    size_w  = Funct3M[1];
    size_h  = (Funct3M[1:0] == 2'b01);
    aligned = size_w ? (AluResultM[1:0] == 2'b00) :
              size_h ? ~AluResultM[0] : 1'b1;
    if (size_w) begin
      be_new    = 4'b1111;
      wdata_new = WriteDataM;
    end else if (size_h) begin
      be_new    = AluResultM[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{WriteDataM[15:0]}};
    end else begin
      be_new    = 4'b0001 << AluResultM[1:0];
      wdata_new = {4{WriteDataM[7:0]}};
    end
  end

  // Load lane extraction from the latched byte offset
  always_comb begin
    rd_shift = BusRdata >> {off_q, 3'b000};
    ld_byte  = rd_shift[7:0];
    ld_half  = off_q[1] ? BusRdata[31:16] : BusRdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = BusRdata;
    endcase
  end

  // An ack in the last allowed cycle still completes the access
  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST) && !BusAck;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    word_d  = word_q;
    off_d   = off_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && aligned) begin
          state_d = S_BUSY;
          cnt_d   = 16'd0;
          we_d    = MemWriteM;
          word_d  = AluResultM[31:2];
          off_d   = AluResultM[1:0];
          be_d    = be_new;
          wdata_d = wdata_new;
          f3_d    = Funct3M;
        end
      end
      S_BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 16'd1;
        if (BusAck) begin
          state_d = S_DONE;
          rdata_d = we_q ? '0 : ld_ext;
        end else if (timed_out) begin
          state_d = S_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      word_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      word_q  <= word_d;
      off_q   <= off_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Stall covers the issuing IDLE cycle and every BUSY cycle; the pipeline
  // advances at the end of DONE. Gated by RST_N so reset releases it at once.
  assign StallM    = RST_N && (((state_q == S_IDLE) && access && aligned) ||
                               (state_q == S_BUSY));
  assign MisalignM = RST_N && (state_q == S_IDLE) && access && !aligned;
  assign BusReq    = (state_q == S_BUSY);
  assign BusWe     = we_q;
  assign BusAddr   = {word_q, 2'b00};
  assign BusBe     = be_q;
  assign BusWdata  = wdata_q;
  assign ReadDataM = rdata_q;
  assign BusErrM   = err_q;
  assign DbgState  = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] AluResultM, WriteDataM, ReadDataM;
  logic        StallM, MisalignM, BusErrM, BusReq, BusWe;
  logic [31:0] BusAddr, BusWdata, BusRdata;
  logic [3:0]  BusBe;
  logic        BusAck;
  logic [1:0]  DbgState;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  mem_stage_lsu #(.WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .AluResultM(AluResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .BusErrM(BusErrM), .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr),
    .BusWdata(BusWdata), .BusBe(BusBe), .BusRdata(BusRdata), .BusAck(BusAck),
    .DbgState(DbgState)
  );

  // clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: access size in bytes from funct3
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    int sz = size_of(f3);
    logic [31:0] mask, val;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    val  = (rdata >> (8 * off)) & mask;
    if (!f3[2] && sz < 4 && val[8 * sz - 1]) val = val | ~mask;
    return val;
  endfunction

  // driver: issue one access from IDLE and follow it to completion
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int wait_cyc, input bit no_ack);
    int sz = size_of(f3);
    logic [1:0] off = addr[1:0];
    logic [3:0] ebe;
    logic [31:0] ewd;
    int busy_n, stall_cnt;
    ebe = 4'(((1 << sz) - 1) << off);
    for (int j = 0; j < 4; j++) ewd[8*j +: 8] = wd[8*(j % sz) +: 8];
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; AluResultM = addr; WriteDataM = wd;
    #1;
    if ((addr % sz) != 0) begin
      check("mis_pulse", {31'd0, MisalignM}, 32'd1);
      check("mis_stall", {31'd0, StallM}, 32'd0);
      check("mis_req", {31'd0, BusReq}, 32'd0);
      @(posedge CLK); #1;
      MemReadM = 1'b0; MemWriteM = 1'b0; #1;
      check("mis_pulse_end", {31'd0, MisalignM}, 32'd0);
      check("mis_req_after", {31'd0, BusReq}, 32'd0);
      return;
    end
    check("issue_mis", {31'd0, MisalignM}, 32'd0);
    check("issue_stall", {31'd0, StallM}, 32'd1);
    stall_cnt = int'(StallM);
    exp_q.push_back((wr || no_ack) ? 32'd0 : model_load(f3, off, rdata));
    busy_n = no_ack ? TO : wait_cyc + 1;
    for (int i = 0; i < busy_n; i++) begin
      @(posedge CLK); #1;
      check("busy_req", {31'd0, BusReq}, 32'd1);
      check("busy_stall", {31'd0, StallM}, 32'd1);
      check("busy_we", {31'd0, BusWe}, {31'd0, wr});
      check("busy_addr", BusAddr, addr & 32'hFFFF_FFFC);
      check("busy_be", {28'd0, BusBe}, {28'd0, ebe});
      check("busy_wdata", BusWdata, ewd);
      check("busy_err", {31'd0, BusErrM}, 32'd0);
      stall_cnt += int'(StallM);
      if (!no_ack && i == wait_cyc) begin
        BusAck = 1'b1; BusRdata = rdata;
      end else begin
        BusAck = 1'b0; BusRdata = $urandom;
      end
    end
    @(posedge CLK); #1;
    BusAck = 1'b0;
    check("done_req", {31'd0, BusReq}, 32'd0);
    check("done_stall", {31'd0, StallM}, 32'd0);
    check("done_err", {31'd0, BusErrM}, {31'd0, no_ack});
    check("done_rdata", ReadDataM, exp_q.pop_front());
    if (!no_ack) check("stall_len", stall_cnt, wait_cyc + 2);
    MemReadM = 1'b0; MemWriteM = 1'b0;
    @(posedge CLK); #1;
    check("idle_err", {31'd0, BusErrM}, 32'd0);
    check("idle_stall", {31'd0, StallM}, 32'd0);
    check("idle_req", {31'd0, BusReq}, 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] addr;
    bit rd, wr;
    RST_N = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    AluResultM = '0; WriteDataM = '0; BusRdata = '0; BusAck = 1'b0;

    // reset
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req", {31'd0, BusReq}, 32'd0);
    check("rst_stall", {31'd0, StallM}, 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    check("rst_err", {31'd0, BusErrM}, 32'd0);
    check("rst_mis", {31'd0, MisalignM}, 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // directed: LB 0x103, ack in first busy cycle
    run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0);
    check("lb_literal", model_load(3'b000, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
    // SH 0x102
    run_access(0, 1, 3'b001, 32'h102, 32'hDEAD_BEEF, 32'h0, 0, 0);
    // LHU 0x200 with 3 wait states
    run_access(1, 0, 3'b101, 32'h200, 32'h0, 32'h0000_9ABC, 3, 0);
    // LW misaligned
    run_access(1, 0, 3'b010, 32'h1001, 32'h0, 32'h0, 0, 0);
    // timeout on a load
    run_access(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 1);
    // both read and write: write wins
    run_access(1, 1, 3'b010, 32'h500, 32'h1234_5678, 32'hFFFF_FFFF, 1, 0);

    // stray acks in IDLE are ignored
    BusAck = 1'b1; BusRdata = 32'hA5A5_A5A5;
    repeat (2) begin
      @(posedge CLK); #1;
      check("stray_req", {31'd0, BusReq}, 32'd0);
      check("stray_stall", {31'd0, StallM}, 32'd0);
    end
    BusAck = 1'b0;
    run_access(1, 0, 3'b100, 32'h601, 32'h0, 32'h0000_F700, 0, 0);

    // reset in second busy cycle
    MemWriteM = 1'b1; Funct3M = 3'b010; AluResultM = 32'h300; WriteDataM = 32'h0BAD_F00D;
    @(posedge CLK); #1;
    check("rb_busy1", {31'd0, BusReq}, 32'd1);
    @(posedge CLK); #1;
    check("rb_busy2", {31'd0, BusReq}, 32'd1);
    RST_N = 1'b0; #1;
    check("rb_req", {31'd0, BusReq}, 32'd0);
    check("rb_stall", {31'd0, StallM}, 32'd0);
    @(posedge CLK); #1;
    MemWriteM = 1'b0; RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rb_idle_req", {31'd0, BusReq}, 32'd0);
    run_access(0, 1, 3'b010, 32'h300, 32'h0BAD_F00D, 32'h0, 1, 0);

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom & 32'h0000_FFFF;
      rd   = 1'($urandom_range(0, 1));
      wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      run_access(rd, wr, f3, addr, $urandom, $urandom, $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
